// File: rtl/button_debounce_pulse_pkg.sv
// rtl/button_debounce_pulse_pkg.sv - shared state encoding, key indices and cycle defaults
package button_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned PREV        = 0;
  localparam int unsigned NEXT        = 1;
  localparam int unsigned OKAY        = 2;
  localparam int unsigned CANCEL      = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  // Counter must hold the largest terminal count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one key: 2-flop synchronizer, debounce FSM and counter
// Auto-repeat while held is built only when BTN_AUTO_REPEAT_EN is defined.
module button_debounce_channel
  import button_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic key_n,
  output logic pulse,
  output logic level
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic repeating;
`endif

  logic [1:0]       sync_q;
  logic             pressed;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer stays live when disabled so a held key is already visible on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], ~key_n};
  end

  assign pressed = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      repeating <= 1'b0;
`endif
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      repeating <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pressed) state <= PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= HELD;
            cnt   <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            repeating <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (cnt == (repeating ? PER_LAST : DLY_LAST)) begin
            cnt       <= '0;
            pulse     <= 1'b1;
            repeating <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        REL_CHK: begin
          if (pressed) begin
            // Release bounce: back to held without a pulse, repeat delay starts over.
            state <= HELD;
            cnt   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            repeating <= 1'b0;
`endif
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// rtl/button_debounce_pulse.sv - four-key debouncer with one-cycle press pulses
// Optional auto-repeat while held: define BTN_AUTO_REPEAT_EN.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_BUTTONS-1:0] iButton,
  output logic [NUM_BUTTONS-1:0] oButton,
  output logic [NUM_BUTTONS-1:0] oLevel
);

  logic [1:0] en_q;
  logic       en_run;

  // Enable rises through the same two-stage delay as the keys, so a key held
  // across en rising is accepted with the same latency as after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 2'b00;
    else        en_q <= {en_q[0], en};
  end

  assign en_run = en & en_q[0] & en_q[1];

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_prev (
    .clk(clk), .rst_n(rst_n), .en(en_run), .key_n(iButton[PREV]),
    .pulse(oButton[PREV]), .level(oLevel[PREV])
  );

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_next (
    .clk(clk), .rst_n(rst_n), .en(en_run), .key_n(iButton[NEXT]),
    .pulse(oButton[NEXT]), .level(oLevel[NEXT])
  );

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_okay (
    .clk(clk), .rst_n(rst_n), .en(en_run), .key_n(iButton[OKAY]),
    .pulse(oButton[OKAY]), .level(oLevel[OKAY])
  );

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_cancel (
    .clk(clk), .rst_n(rst_n), .en(en_run), .key_n(iButton[CANCEL]),
    .pulse(oButton[CANCEL]), .level(oLevel[CANCEL])
  );

endmodule

// File: tb/tb_button_debounce_pulse.sv
// tb/tb_button_debounce_pulse.sv - directed table and corner sequences for button_debounce_pulse
module tb_button_debounce_pulse;
  import button_debounce_pulse_pkg::*;

  localparam int DEB = 8;
  localparam int RD  = 32;
  localparam int RP  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] iButton = 4'hF;
  logic [3:0] oButton;
  logic [3:0] oLevel;

  always #5 clk = ~clk;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iButton(iButton),
    .oButton(oButton), .oLevel(oLevel)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] btn;
    int         cycles;
    logic [3:0] exp_pulse;
    logic [3:0] exp_level;
    string      name;
  } vec_t;

  vec_t vecs[14];

  int n_checks = 0;
  int n_fail   = 0;

  int         now;
  int         pcount[4];
  int         ptime[4][8];
  int         lrise[4];
  int         lfall[4];
  int         bad_cnt;
  logic [3:0] lvl_prev;

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] b, input int c,
                              input logic [3:0] p, input logic [3:0] l, input string n);
    vec_t v;
    v.rst_n = r; v.en = e; v.btn = b; v.cycles = c;
    v.exp_pulse = p; v.exp_level = l; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic seq_start();
    now = 0;
    bad_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      pcount[c] = 0;
      lrise[c]  = -1;
      lfall[c]  = -1;
    end
    lvl_prev = oLevel;
  endtask

  task automatic step_rec();
    @(posedge clk);
    #1;
    now++;
    for (int c = 0; c < 4; c++) begin
      if (oButton[c]) begin
        if (pcount[c] < 8) ptime[c][pcount[c]] = now;
        pcount[c]++;
      end
      if (oLevel[c] && !lvl_prev[c] && lrise[c] < 0) lrise[c] = now;
      if (!oLevel[c] && lvl_prev[c] && lfall[c] < 0) lfall[c] = now;
    end
    lvl_prev = oLevel;
  endtask

  task automatic settle();
    rst_n = 1'b1;
    en = 1'b1;
    iButton = 4'hF;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int others(input int c);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) if (i != c) s += pcount[i];
    return s;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Keys are active-low on iButton; expected outputs are 1 = pressed.
    vecs[0]  = mk(1'b0, 1'b1, 4'hF,    2,  4'h0,    4'h0,    "reset");
    vecs[1]  = mk(1'b1, 1'b1, 4'hF,    5,  4'h0,    4'h0,    "idle");
    vecs[2]  = mk(1'b1, 1'b1, 4'hE,    10, 4'h0,    4'h0,    "prev_qualifying");
    vecs[3]  = mk(1'b1, 1'b1, 4'hE,    1,  4'h1,    4'h1,    "prev_accept");
    vecs[4]  = mk(1'b1, 1'b1, 4'hE,    1,  4'h0,    4'h1,    "prev_held");
    vecs[5]  = mk(1'b1, 1'b1, 4'hF,    10, 4'h0,    4'h1,    "prev_rel_qual");
    vecs[6]  = mk(1'b1, 1'b1, 4'hF,    1,  4'h0,    4'h0,    "prev_rel_done");
    vecs[7]  = mk(1'b1, 1'b1, 4'b0110, 11, 4'b1001, 4'b1001, "simul_accept");
    vecs[8]  = mk(1'b1, 1'b1, 4'b0110, 1,  4'h0,    4'b1001, "simul_held");
    vecs[9]  = mk(1'b1, 1'b1, 4'hF,    11, 4'h0,    4'h0,    "simul_release");
    vecs[10] = mk(1'b1, 1'b0, 4'h0,    5,  4'h0,    4'h0,    "en_off_held");
    vecs[11] = mk(1'b1, 1'b1, 4'h0,    11, 4'hF,    4'hF,    "en_on_accept");
    vecs[12] = mk(1'b1, 1'b1, 4'h0,    1,  4'h0,    4'hF,    "en_on_held");
    vecs[13] = mk(1'b1, 1'b1, 4'hF,    11, 4'h0,    4'h0,    "all_release");

    #1;
    for (int i = 0; i < 14; i++) begin
      rst_n   = vecs[i].rst_n;
      en      = vecs[i].en;
      iButton = vecs[i].btn;
      for (int j = 0; j < vecs[i].cycles; j++) begin
        @(posedge clk);
        #1;
      end
      check({vecs[i].name, "_pulse"}, 32'(oButton), 32'(vecs[i].exp_pulse));
      check({vecs[i].name, "_level"}, 32'(oLevel), 32'(vecs[i].exp_level));
    end

    // Clean press on NEXT, held 40 cycles.
    settle();
    seq_start();
    for (int k = 0; k < 60; k++) begin
      iButton = 4'hF;
      iButton[NEXT] = (k < 40) ? 1'b0 : 1'b1;
      step_rec();
    end
    check("clean_count", pcount[NEXT], 1);
    check("clean_time", ptime[NEXT][0], DEB + 3);
    check("clean_level_rise", lrise[NEXT], DEB + 3);
    check("clean_level_fall", lfall[NEXT], 40 + DEB + 3);
    check("clean_others", others(NEXT), 0);

    // Bounce on OKAY: toggles every 3 cycles, last falling edge at k=30.
    settle();
    seq_start();
    for (int k = 0; k < 70; k++) begin
      iButton = 4'hF;
      if (k < 30) iButton[OKAY] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      else        iButton[OKAY] = (k < 50) ? 1'b0 : 1'b1;
      step_rec();
    end
    check("bounce_count", pcount[OKAY], 1);
    check("bounce_time", ptime[OKAY][0], 30 + DEB + 3);
    check("bounce_others", others(OKAY), 0);

    // Release glitch on NEXT: 4 high cycles while held.
    settle();
    seq_start();
    for (int k = 0; k < 60; k++) begin
      iButton = 4'hF;
      iButton[NEXT] = (k < 40 && !(k >= 15 && k <= 18)) ? 1'b0 : 1'b1;
      step_rec();
      if (now >= DEB + 3 && now <= 40 && !oLevel[NEXT]) bad_cnt++;
    end
    check("glitch_count", pcount[NEXT], 1);
    check("glitch_time", ptime[NEXT][0], DEB + 3);
    check("glitch_level_drops", bad_cnt, 0);
    check("glitch_level_fall", lfall[NEXT], 40 + DEB + 3);

    // Long hold on NEXT for 100 cycles.
    settle();
    seq_start();
    for (int k = 0; k < 120; k++) begin
      iButton = 4'hF;
      iButton[NEXT] = (k < 100) ? 1'b0 : 1'b1;
      step_rec();
    end
`ifdef BTN_AUTO_REPEAT_EN
    begin
      int exp_rep[5];
      exp_rep[0] = DEB + 3;
      for (int r = 1; r < 5; r++) exp_rep[r] = DEB + 3 + RD + (r - 1) * RP;
      check("repeat_count", pcount[NEXT], 5);
      for (int r = 0; r < 5; r++) check($sformatf("repeat_time%0d", r), ptime[NEXT][r], exp_rep[r]);
    end
`else
    check("hold_count", pcount[NEXT], 1);
    check("hold_time", ptime[NEXT][0], DEB + 3);
`endif
    check("hold_level_fall", lfall[NEXT], 100 + DEB + 3);

    // Reset mid-PRESS_CHK on OKAY, key still held afterwards.
    settle();
    seq_start();
    for (int k = 0; k < 45; k++) begin
      iButton = 4'hF;
      iButton[OKAY] = (k < 30) ? 1'b0 : 1'b1;
      rst_n = (k >= 6 && k <= 8) ? 1'b0 : 1'b1;
      step_rec();
      if (!rst_n && (oButton != 4'h0 || oLevel != 4'h0)) bad_cnt++;
    end
    check("rst_outputs_zero", bad_cnt, 0);
    check("rst_count", pcount[OKAY], 1);
    check("rst_time", ptime[OKAY][0], 9 + DEB + 3);

    // Enable dropped mid-PRESS_CHK on OKAY, key still held afterwards.
    settle();
    seq_start();
    for (int k = 0; k < 45; k++) begin
      iButton = 4'hF;
      iButton[OKAY] = (k < 30) ? 1'b0 : 1'b1;
      en = (k >= 6 && k <= 8) ? 1'b0 : 1'b1;
      step_rec();
      if (!en && (oButton != 4'h0 || oLevel != 4'h0)) bad_cnt++;
    end
    check("en_outputs_zero", bad_cnt, 0);
    check("en_count", pcount[OKAY], 1);
    check("en_time", ptime[OKAY][0], 9 + DEB + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
